// File: rtl/rtr_link_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : rtr_link_arbiter
// Description : Round-robin arbiter sharing one byte-serial router output
//               link among NUM_IN sources using the free/put handshake.
//               Grants are held for one whole packet and each forwarded byte
//               passes through one register stage.
// Revision    : 1.0 - initial release
// ============================================================================
module rtr_link_arbiter #(
  parameter int NUM_IN    = 4,
  parameter int PKT_BYTES = 4,
  parameter int TIMEOUT   = 15
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NUM_IN-1:0]         req_in,
  output logic [NUM_IN-1:0]         free_in,
  input  logic [NUM_IN-1:0]         put_in,
  input  logic [NUM_IN*8-1:0]       payload_in,
  input  logic                      free_out,
  output logic                      put_out,
  output logic [7:0]                payload_out,
  output logic [$clog2(NUM_IN)-1:0] grant_id,
  output logic                      busy,
  output logic                      timeout_err,
  output logic                      spurious_put
);

  localparam int IDW = $clog2(NUM_IN);
  localparam int BCW = $clog2(PKT_BYTES + 1);
  localparam int ICW = $clog2(TIMEOUT + 1);

  localparam logic [IDW-1:0] LAST_ID    = IDW'(NUM_IN - 1);
  localparam logic [BCW-1:0] LAST_BYTE  = BCW'(PKT_BYTES - 1);
  localparam logic [ICW-1:0] IDLE_LIMIT = ICW'(TIMEOUT);
  localparam logic [ICW-1:0] IDLE_MAX   = '1;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_XFER = 2'd2
  } state_t;

  state_t         state_q,       state_d;
  logic [IDW-1:0] grant_id_q,    grant_id_d;
  logic [IDW-1:0] rr_ptr_q,      rr_ptr_d;
  logic [BCW-1:0] byte_cnt_q,    byte_cnt_d;
  logic [ICW-1:0] idle_cnt_q,    idle_cnt_d;
  logic           put_out_q,     put_out_d;
  logic [7:0]     payload_out_q, payload_out_d;
  logic           timeout_q,     timeout_d;
  logic           spurious_q,    spurious_d;

  logic [7:0]     lane [NUM_IN];
  logic           win_found;
  logic [IDW-1:0] win_idx;
  logic [IDW-1:0] next_ptr;
  logic           gnt_put;

  // Per-source byte lanes unpacked from the flattened payload bus
  for (genvar gi = 0; gi < NUM_IN; gi++) begin : g_lane
    assign lane[gi] = payload_in[8*gi +: 8];
  end

  // Grant vector is derived from the state register so reset clears it at once
  assign free_in  = (state_q == ST_IDLE) ? '0
                  : ({{(NUM_IN-1){1'b0}}, 1'b1} << grant_id_q);
  assign busy     = (state_q != ST_IDLE);
  assign gnt_put  = (state_q != ST_IDLE) && put_in[grant_id_q];
  assign next_ptr = (grant_id_q == LAST_ID) ? '0 : grant_id_q + 1'b1;

  assign grant_id     = grant_id_q;
  assign put_out      = put_out_q;
  assign payload_out  = payload_out_q;
  assign timeout_err  = timeout_q;
  assign spurious_put = spurious_q;

  // Round-robin search: scan offsets high to low so the nearest request at or after rr_ptr wins
  always_comb begin
    int             idx;
    logic [IDW-1:0] idx_l;
    win_found = 1'b0;
    win_idx   = '0;
    idx       = 0;
    idx_l     = '0;
    for (int k = NUM_IN - 1; k >= 0; k--) begin
      idx = int'(rr_ptr_q) + k;
      if (idx >= NUM_IN) begin
        idx = idx - NUM_IN;
      end
      idx_l = IDW'(idx);
      if (req_in[idx_l]) begin
        win_found = 1'b1;
        win_idx   = idx_l;
      end
    end
  end

  // Next-state logic: grant in IDLE, forward bytes and track completion/idle time while granted
  always_comb begin
    state_d       = state_q;
    grant_id_d    = grant_id_q;
    rr_ptr_d      = rr_ptr_q;
    byte_cnt_d    = byte_cnt_q;
    idle_cnt_d    = idle_cnt_q;
    put_out_d     = 1'b0;
    payload_out_d = payload_out_q;
    timeout_d     = 1'b0;
    // Any put from a source that does not hold the grant is flagged and dropped
    spurious_d    = |(put_in & ~free_in);

    case (state_q)
      ST_IDLE: begin
        if (free_out && win_found) begin
          state_d    = ST_WAIT;
          grant_id_d = win_idx;
          byte_cnt_d = '0;
          idle_cnt_d = '0;
        end
      end
      ST_WAIT, ST_XFER: begin
        if (gnt_put) begin
          put_out_d     = 1'b1;
          payload_out_d = lane[grant_id_q];
          byte_cnt_d    = byte_cnt_q + 1'b1;
          idle_cnt_d    = '0;
          if (byte_cnt_q == LAST_BYTE) begin
            state_d  = ST_IDLE;
            rr_ptr_d = next_ptr;
          end else begin
            state_d  = ST_XFER;
          end
        end else if (idle_cnt_q == IDLE_LIMIT) begin
          // Source stalled too long: abandon the grant, already-forwarded bytes stay sent
          timeout_d = 1'b1;
          state_d   = ST_IDLE;
          rr_ptr_d  = next_ptr;
        end else if (idle_cnt_q != IDLE_MAX) begin
          idle_cnt_d = idle_cnt_q + 1'b1;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and datapath registers, all cleared asynchronously
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= ST_IDLE;
      grant_id_q    <= '0;
      rr_ptr_q      <= '0;
      byte_cnt_q    <= '0;
      idle_cnt_q    <= '0;
      put_out_q     <= 1'b0;
      payload_out_q <= '0;
      timeout_q     <= 1'b0;
      spurious_q    <= 1'b0;
    end else begin
      state_q       <= state_d;
      grant_id_q    <= grant_id_d;
      rr_ptr_q      <= rr_ptr_d;
      byte_cnt_q    <= byte_cnt_d;
      idle_cnt_q    <= idle_cnt_d;
      put_out_q     <= put_out_d;
      payload_out_q <= payload_out_d;
      timeout_q     <= timeout_d;
      spurious_q    <= spurious_d;
    end
  end

endmodule
`default_nettype wire
